bwt_backward_ext_pipe: RTL
==========================

Name: bwt_backward_ext_pipe

Overview:
- Parametrised next-generation backward-extension datapath for the SMEM pipeline.
- Takes one token per cycle: interval (k,l), per-base occurrence counts, the x1 seed and the selected base c.
- Computes the backward-extended bi-interval for all four bases and selects base c. Tests the result against min_intv, then either stores it to the curr array and issues the next occurrence memory request, or drops it.
- Replaces the global stall with elastic valid/ready flow control over a configurable-depth pipeline, and adds per-block kept/dropped statistics.

Parameters:
- CNT_W, 64, width of k/l/occ/x0/x1/x2/primary/L2/min_intv.
- RN_W, 8, read-number (token tag) width.
- ADDR_W, 7, curr-array address width.
- PIPE_DEPTH, 3, number of register stages (legal 2..8).
- OCC_SHIFT, 7, right shift from BWT position to occurrence-bucket address.
- REQ_W, 42, memory request address width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-low reset.
- cfg_l2  in  4*CNT_W  cumulative base counts L2[0..3], base0 at LSBs; static while tokens are in flight.
- cfg_primary  in  CNT_W  BWT primary (sentinel) position; static.
- in_valid  in  1  token valid.
- in_ready  out  1  token accepted when in_valid&&in_ready.
- in_read_num  in  RN_W  tag.
- in_k  in  CNT_W  interval low.
- in_l  in  CNT_W  interval high.
- in_ik_x1  in  CNT_W  x1 of current interval.
- in_occ_k  in  4*CNT_W  occ(b,k) per base.
- in_occ_l  in  4*CNT_W  occ(b,l) per base.
- in_c  in  2  extension base.
- in_min_intv  in  CNT_W  minimum interval size.
- in_wr_addr  in  ADDR_W  next curr-array slot for this read.
- in_last  in  1  iteration boundary marker.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts.
- out_read_num  out  RN_W  tag.
- out_x0, out_x1, out_x2  out  CNT_W each  selected extended interval.
- out_keep  out  1  out_x2 >= min_intv.
- out_wr_addr  out  ADDR_W  updated slot (in_wr_addr+keep).
- out_last  out  1  in_last delayed.
- store_valid_curr  out  1  curr-array write strobe.
- curr_addr  out  ADDR_W  write address.
- curr_x0, curr_x1, curr_x2  out  CNT_W each  write data.
- req_valid  out  1  memory request strobe.
- req_addr_k, req_addr_l  out  REQ_W each  bucket addresses.
- kept_cnt, drop_cnt  out  32 each  saturating statistics.

Behaviour:
- Reset: synchronous, active-low; applied on the clk edge when rst=0.
  - All stage valid bits, out_valid, store_valid_curr, req_valid, kept_cnt and drop_cnt are cleared to 0. Data registers are don't-care.
  - Reset mid-flight discards all tokens. in_ready=1 in the first cycle after release.
- Elastic pipeline:
  - Stage i loads when !v[i] || stage i+1 loads; the last stage advances on out_ready.
  - in_ready = stage-0 load enable. No bubbles required: 1 token/cycle, latency PIPE_DEPTH cycles with out_ready held 1.
  - When out_ready=0 every output holds stable. No token is lost or duplicated, and order is preserved.
- Stage 0, per base b, all arithmetic mod 2^CNT_W:
  - x0[b] = L2[b] + occ_k[b] + 1
  - x2[b] = occ_l[b] - occ_k[b]
  - sent = (k < primary) && (primary <= l), unsigned compares.
- Stage 1:
  - x1[3] = ik_x1 + sent
  - x1[2] = x1[3] + x2[3]
  - x1[1] = x1[2] + x2[2]
  - x1[0] = x1[1] + x2[1]
  - Select base c; keep = (x2[c] >= min_intv).
- Stages 2..PIPE_DEPTH-1 are pure delay. When PIPE_DEPTH=2, stage 1 is the output register.
- Output handshake (out_valid && out_ready):
  - If keep: store_valid_curr=1 for exactly that cycle, with curr_addr=in_wr_addr, curr_x* = result, and out_wr_addr = in_wr_addr+1 (wraps mod 2^ADDR_W).
  - If keep: req_valid=1 in the same cycle, with req_addr_k = (x0-1)>>OCC_SHIFT and req_addr_l = (x0+x2-1)>>OCC_SHIFT, truncated to REQ_W.
  - If !keep: no store and no request; out_wr_addr = in_wr_addr.
  - Strobes are never asserted without a handshake.
- Counters: kept_cnt increments on each kept handshake and drop_cnt on each dropped handshake. Each saturates at 0xFFFFFFFF.
- The x2 = 0 result with min_intv = 0 counts as keep.

Test Plan:
- Reset/flow: hold rst=0 for 2 cycles with in_valid=1 -> out_valid=0, counters 0; in_ready=1 in the first cycle after release.
- Arithmetic, sentinel case: L2={0,10,20,30}, primary=15, k=9, l=19, ik_x1=50, occ_k={2,3,1,3}, occ_l={5,4,4,7}, c=2, min_intv=3, wr_addr=5 -> after 3 cycles out x0=22, x1=55, x2=3, keep=1. Store at addr 5, out_wr_addr=6, req_addr_k=0, req_addr_l=0, kept_cnt=1.
- Same token with c=1 -> x0=14, x1=58, x2=1, keep=0. No store or request, out_wr_addr=5, drop_cnt=1.
- No sentinel: primary=5, same token, c=3 -> x1=50, x0=34, x2=4.
- Backpressure: 10 back-to-back tokens with tags 0..9, out_ready toggling 1,0,0,1 -> tags exit in order 0..9. Outputs stable while stalled; exactly 10 handshakes.
- Wrap/saturation: wr_addr=127 with keep -> out_wr_addr=0. Preload drop_cnt to 0xFFFFFFFF by forcing, then one drop -> stays 0xFFFFFFFF.

Source files
------------

// File: rtl/bwt_backward_ext_pipe_if.sv
// Token and result bus of the SMEM backward-extension pipeline.
// master = upstream/downstream environment, slave = the extension datapath.
interface bwt_backward_ext_pipe_if #(
  parameter int CNT_W  = 64,
  parameter int RN_W   = 8,
  parameter int ADDR_W = 7,
  parameter int REQ_W  = 42
);
  logic                  in_valid;
  logic                  in_ready;
  logic [RN_W-1:0]       in_read_num;
  logic [CNT_W-1:0]      in_k;
  logic [CNT_W-1:0]      in_l;
  logic [CNT_W-1:0]      in_ik_x1;
  logic [4*CNT_W-1:0]    in_occ_k;
  logic [4*CNT_W-1:0]    in_occ_l;
  logic [1:0]            in_c;
  logic [CNT_W-1:0]      in_min_intv;
  logic [ADDR_W-1:0]     in_wr_addr;
  logic                  in_last;

  logic                  out_valid;
  logic                  out_ready;
  logic [RN_W-1:0]       out_read_num;
  logic [CNT_W-1:0]      out_x0;
  logic [CNT_W-1:0]      out_x1;
  logic [CNT_W-1:0]      out_x2;
  logic                  out_keep;
  logic [ADDR_W-1:0]     out_wr_addr;
  logic                  out_last;

  logic                  store_valid_curr;
  logic [ADDR_W-1:0]     curr_addr;
  logic [CNT_W-1:0]      curr_x0;
  logic [CNT_W-1:0]      curr_x1;
  logic [CNT_W-1:0]      curr_x2;
  logic                  req_valid;
  logic [REQ_W-1:0]      req_addr_k;
  logic [REQ_W-1:0]      req_addr_l;
  logic [31:0]           kept_cnt;
  logic [31:0]           drop_cnt;

  modport master (
    output in_valid, in_read_num, in_k, in_l, in_ik_x1, in_occ_k, in_occ_l,
           in_c, in_min_intv, in_wr_addr, in_last, out_ready,
    input  in_ready, out_valid, out_read_num, out_x0, out_x1, out_x2, out_keep,
           out_wr_addr, out_last, store_valid_curr, curr_addr, curr_x0, curr_x1,
           curr_x2, req_valid, req_addr_k, req_addr_l, kept_cnt, drop_cnt
  );

  modport slave (
    input  in_valid, in_read_num, in_k, in_l, in_ik_x1, in_occ_k, in_occ_l,
           in_c, in_min_intv, in_wr_addr, in_last, out_ready,
    output in_ready, out_valid, out_read_num, out_x0, out_x1, out_x2, out_keep,
           out_wr_addr, out_last, store_valid_curr, curr_addr, curr_x0, curr_x1,
           curr_x2, req_valid, req_addr_k, req_addr_l, kept_cnt, drop_cnt
  );
endinterface

// File: rtl/bwt_backward_ext_pipe.sv
// Elastic backward-extension datapath: computes the extended bi-interval for base c,
// filters on min_intv, and emits curr-array stores and occurrence-bucket requests.
module bwt_backward_ext_pipe #(
  parameter int CNT_W      = 64,
  parameter int RN_W       = 8,
  parameter int ADDR_W     = 7,
  parameter int PIPE_DEPTH = 3,
  parameter int OCC_SHIFT  = 7,
  parameter int REQ_W      = 42
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [4*CNT_W-1:0]   cfg_l2,
  input  logic [CNT_W-1:0]     cfg_primary,
  bwt_backward_ext_pipe_if.slave bus
);
  localparam int D = PIPE_DEPTH;
  localparam logic [CNT_W-1:0] ONE_C = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef struct packed {
    logic [RN_W-1:0]    read_num;
    logic [4*CNT_W-1:0] x0;
    logic [4*CNT_W-1:0] x2;
    logic               sent;
    logic [CNT_W-1:0]   ik_x1;
    logic [1:0]         c;
    logic [CNT_W-1:0]   min_intv;
    logic [ADDR_W-1:0]  wr_addr;
    logic               last;
  } s0_t;

  typedef struct packed {
    logic [RN_W-1:0]   read_num;
    logic [CNT_W-1:0]  x0;
    logic [CNT_W-1:0]  x1;
    logic [CNT_W-1:0]  x2;
    logic              keep;
    logic [ADDR_W-1:0] wr_addr;
    logic [ADDR_W-1:0] nxt_addr;
    logic              last;
  } res_t;

  logic [D-1:0]     v_r;
  logic [D-1:0]     ld_s;
  s0_t              s0_r;
  s0_t              s0_nxt_s;
  res_t             res_r [1:D-1];
  res_t             res_nxt_s;
  res_t             tail_s;
  logic [CNT_W-1:0] x1_0_s, x1_1_s, x1_2_s, x1_3_s;
  logic [CNT_W-1:0] sel_x0_s, sel_x1_s, sel_x2_s;
  logic             hs_s;
  logic [31:0]      kept_cnt_r;
  logic [31:0]      drop_cnt_r;

  // Load enables: a stage loads when empty or when everything after it can move.
  always_comb begin
    logic rdy_v;
    rdy_v = bus.out_ready;
    ld_s  = '0;
    for (int i = D - 1; i >= 0; i--) begin
      rdy_v   = !v_r[i] || rdy_v;
      ld_s[i] = rdy_v;
    end
  end

  // Stage-0 arithmetic for all four bases plus the sentinel test.
  always_comb begin
    s0_nxt_s          = '0;
    s0_nxt_s.read_num = bus.in_read_num;
    for (int b = 0; b < 4; b++) begin
      s0_nxt_s.x0[b*CNT_W +: CNT_W] = cfg_l2[b*CNT_W +: CNT_W] + bus.in_occ_k[b*CNT_W +: CNT_W] + ONE_C;
      s0_nxt_s.x2[b*CNT_W +: CNT_W] = bus.in_occ_l[b*CNT_W +: CNT_W] - bus.in_occ_k[b*CNT_W +: CNT_W];
    end
    s0_nxt_s.sent     = (bus.in_k < cfg_primary) && (cfg_primary <= bus.in_l);
    s0_nxt_s.ik_x1    = bus.in_ik_x1;
    s0_nxt_s.c        = bus.in_c;
    s0_nxt_s.min_intv = bus.in_min_intv;
    s0_nxt_s.wr_addr  = bus.in_wr_addr;
    s0_nxt_s.last     = bus.in_last;
  end

  // x1 accumulates the interval sizes of the bases above b, starting at ik_x1 + sentinel.
  assign x1_3_s = s0_r.ik_x1 + {{(CNT_W-1){1'b0}}, s0_r.sent};
  assign x1_2_s = x1_3_s + s0_r.x2[3*CNT_W +: CNT_W];
  assign x1_1_s = x1_2_s + s0_r.x2[2*CNT_W +: CNT_W];
  assign x1_0_s = x1_1_s + s0_r.x2[1*CNT_W +: CNT_W];

  // Stage-1 base selection.
  always_comb begin
    sel_x0_s = s0_r.x0[0 +: CNT_W];
    sel_x1_s = x1_0_s;
    sel_x2_s = s0_r.x2[0 +: CNT_W];
    case (s0_r.c)
      2'd0: begin
        sel_x0_s = s0_r.x0[0 +: CNT_W];
        sel_x1_s = x1_0_s;
        sel_x2_s = s0_r.x2[0 +: CNT_W];
      end
      2'd1: begin
        sel_x0_s = s0_r.x0[CNT_W +: CNT_W];
        sel_x1_s = x1_1_s;
        sel_x2_s = s0_r.x2[CNT_W +: CNT_W];
      end
      2'd2: begin
        sel_x0_s = s0_r.x0[2*CNT_W +: CNT_W];
        sel_x1_s = x1_2_s;
        sel_x2_s = s0_r.x2[2*CNT_W +: CNT_W];
      end
      2'd3: begin
        sel_x0_s = s0_r.x0[3*CNT_W +: CNT_W];
        sel_x1_s = x1_3_s;
        sel_x2_s = s0_r.x2[3*CNT_W +: CNT_W];
      end
      default: begin
        sel_x0_s = s0_r.x0[0 +: CNT_W];
        sel_x1_s = x1_0_s;
        sel_x2_s = s0_r.x2[0 +: CNT_W];
      end
    endcase
  end

  // Stage-1 result record including the min_intv filter and next slot.
  always_comb begin
    res_nxt_s          = '0;
    res_nxt_s.read_num = s0_r.read_num;
    res_nxt_s.x0       = sel_x0_s;
    res_nxt_s.x1       = sel_x1_s;
    res_nxt_s.x2       = sel_x2_s;
    res_nxt_s.keep     = (sel_x2_s >= s0_r.min_intv);
    res_nxt_s.wr_addr  = s0_r.wr_addr;
    res_nxt_s.nxt_addr = s0_r.wr_addr + {{(ADDR_W-1){1'b0}}, (sel_x2_s >= s0_r.min_intv)};
    res_nxt_s.last     = s0_r.last;
  end

  // Stage valid bits; reset discards everything in flight.
  always_ff @(posedge clk) begin
    if (!rst) begin
      v_r <= '0;
    end else begin
      if (ld_s[0]) v_r[0] <= bus.in_valid;
      for (int i = 1; i < D; i++) begin
        if (ld_s[i]) v_r[i] <= v_r[i-1];
      end
    end
  end

  // Stage data registers; contents only matter where the valid bit is set.
  always_ff @(posedge clk) begin
    if (ld_s[0]) s0_r     <= s0_nxt_s;
    if (ld_s[1]) res_r[1] <= res_nxt_s;
    for (int i = 2; i < D; i++) begin
      if (ld_s[i]) res_r[i] <= res_r[i-1];
    end
  end

  assign tail_s            = res_r[D-1];
  assign hs_s              = v_r[D-1] && bus.out_ready;
  assign bus.in_ready      = ld_s[0];
  assign bus.out_valid     = v_r[D-1];
  assign bus.out_read_num  = tail_s.read_num;
  assign bus.out_x0        = tail_s.x0;
  assign bus.out_x1        = tail_s.x1;
  assign bus.out_x2        = tail_s.x2;
  assign bus.out_keep      = tail_s.keep;
  assign bus.out_wr_addr   = tail_s.nxt_addr;
  assign bus.out_last      = tail_s.last;

  // Store and request fire only on a kept handshake.
  assign bus.store_valid_curr = hs_s && tail_s.keep;
  assign bus.curr_addr        = tail_s.wr_addr;
  assign bus.curr_x0          = tail_s.x0;
  assign bus.curr_x1          = tail_s.x1;
  assign bus.curr_x2          = tail_s.x2;
  assign bus.req_valid        = hs_s && tail_s.keep;
  assign bus.req_addr_k       = REQ_W'((tail_s.x0 - ONE_C) >> OCC_SHIFT);
  assign bus.req_addr_l       = REQ_W'((tail_s.x0 + tail_s.x2 - ONE_C) >> OCC_SHIFT);
  assign bus.kept_cnt         = kept_cnt_r;
  assign bus.drop_cnt         = drop_cnt_r;

  // Saturating kept/dropped statistics.
  always_ff @(posedge clk) begin
    if (!rst) begin
      kept_cnt_r <= 32'd0;
      drop_cnt_r <= 32'd0;
    end else if (hs_s) begin
      if (tail_s.keep) begin
        if (kept_cnt_r != 32'hFFFF_FFFF) kept_cnt_r <= kept_cnt_r + 32'd1;
      end else begin
        if (drop_cnt_r != 32'hFFFF_FFFF) drop_cnt_r <= drop_cnt_r + 32'd1;
      end
    end
  end
endmodule
